// File: rtl/serial_panel_driver.sv
// Multi-channel serial shift-out driver for LED / 7-segment panels.
// Shared sclk/pen/clr, one sdo lane per channel, load/busy/done handshake and auto-refresh.
module serial_panel_driver #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned DIV       = 4,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*WIDTH-1:0]    pdata,
  input  logic                         load,
  input  logic                         auto,
  output logic                         busy,
  output logic                         done,
  output logic                         sclk,
  output logic [CHANNELS-1:0]          sdo,
  output logic                         pen,
  output logic                         clr
);

  localparam int unsigned BIT_W = $clog2(WIDTH);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, LATCH} state_e;

  state_e                      state_q;
  logic [DIV_W-1:0]            div_q;
  logic [BIT_W-1:0]            bit_q;
  logic [CHANNELS*WIDTH-1:0]   shadow_q;
  logic                        first_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        sclk_q;
  logic [CHANNELS-1:0]         sdo_q;
  logic                        pen_q;
  logic                        clr_q;
  logic                        div_end_d;

  assign busy      = busy_q;
  assign done      = done_q;
  assign sclk      = sclk_q;
  assign sdo       = sdo_q;
  assign pen       = pen_q;
  assign clr       = clr_q;
  assign div_end_d = (div_q == DIV_LAST);

  // Bit cnt of every lane; order is folded into the index rather than the data path.
  function automatic logic [CHANNELS-1:0] pick(input logic [CHANNELS*WIDTH-1:0] d,
                                                input logic [BIT_W-1:0] cnt);
    logic [BIT_W-1:0] idx;
    logic [WIDTH-1:0] lane;
    pick = '0;
    idx  = (MSB_FIRST != 0) ? (BIT_LAST - cnt) : cnt;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      lane    = d[c*WIDTH +: WIDTH];
      pick[c] = lane[idx];
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shadow_q <= '0;
      first_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      sdo_q    <= '0;
      pen_q    <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load || auto) begin
            shadow_q <= pdata;
            div_q    <= '0;
            bit_q    <= '0;
            busy_q   <= 1'b1;
            sdo_q    <= pick(pdata, '0);
            state_q  <= first_q ? CLEAR : SHIFT;
          end
        end
        CLEAR: begin
          if (div_end_d) begin
            div_q   <= '0;
            clr_q   <= 1'b1;
            first_q <= 1'b0;
            state_q <= SHIFT;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        SHIFT: begin
          if (!div_end_d) begin
            div_q <= div_q + DIV_W'(1);
          end else begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (bit_q == BIT_LAST) begin
                pen_q   <= 1'b1;
                state_q <= LATCH;
              end else begin
                bit_q <= bit_q + BIT_W'(1);
                sdo_q <= pick(shadow_q, bit_q + BIT_W'(1));
              end
            end
          end
        end
        LATCH: begin
          if (div_end_d) begin
            div_q   <= '0;
            pen_q   <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_panel_driver.md
# serial_panel_driver

Parametrised multi-channel serial shift-out driver for the board's LED and 7-segment panels. It replaces the fixed 16-bit single-channel shift driver and adds several features: configurable width, channel count, bit order and serial clock rate, a load/busy/done handshake, and an auto-refresh mode. It sits between the top-level status buses (mode, command bits, PS/2 byte) and the board's serial panel pins. It drives a shared clock, latch and clear, and one data line per channel.

## Interface
- WIDTH, 16: bits shifted per channel per transfer (≥2).
- CHANNELS, 2: independent data lanes sharing sclk/pen/clr (≥1).
- DIV, 4: serial clock half-period in clk cycles (≥1).
- MSB_FIRST, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- clk  in  1  system clock; all state is on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- pdata  in  CHANNELS*WIDTH  parallel data; channel c occupies [c*WIDTH +: WIDTH].
- load  in  1  transfer request, sampled only in IDLE.
- auto  in  1  when high, IDLE immediately restarts a transfer.
- busy  out  1  high from the cycle after capture until done.
- done  out  1  one-cycle pulse at transfer end.
- sclk  out  1  serial clock; the panel samples on its rising edge.
- sdo  out  CHANNELS  serial data, one bit per channel.
- pen  out  1  latch enable, active-high pulse after the last bit.
- clr  out  1  panel clear, active-low.

## Operation
- States: IDLE, CLEAR, SHIFT, LATCH. Internal signals are a DIV counter, a bit counter (clog2(WIDTH) bits), a CHANNELS×WIDTH shadow register, and a first_flag.
- Reset values: state=IDLE, busy=0, done=0, sclk=0, sdo=0, pen=0, clr=0, first_flag=1, counters=0.
- IDLE:
  - If load|auto, capture pdata into the shadow register and reset the counters.
  - Go to CLEAR if first_flag, else go to SHIFT.
  - Otherwise remain in IDLE.
- CLEAR: hold clr=0 for DIV cycles, then set clr=1, clear first_flag and go to SHIFT. clr stays 1 until the next reset.
- SHIFT: each bit lasts 2*DIV cycles.
  - First DIV cycles: sclk=0, sdo[c] = current bit of channel c.
  - Next DIV cycles: sclk=1, sdo held.
  - Bit selection is a MSB_FIRST-dependent index, not a mux rebuilt per bit.
  - After bit WIDTH-1 completes, set sclk=0 and go to LATCH.
- LATCH: pen=1 for DIV cycles, then pen=0, done=1 for one cycle, busy=0, state=IDLE.
- load asserted while busy is ignored; it is not queued.
- pdata changes during a transfer do not affect the bits being shifted.
- If load and auto are both high, the behaviour is identical to either alone.

## Timing
- Define k as the edge at which IDLE samples load=1. Then busy=1 and the first state cycle begin at k+1.
- Transfer length T = 2*DIV*WIDTH + DIV cycles (LATCH included), plus DIV cycles on the first transfer after reset (CLEAR).
- done=1 in cycle k+1+T, the same cycle busy falls and state is IDLE.
- That IDLE cycle samples load/auto, so auto gives a 1-cycle gap between transfers.
- sdo changes only on sclk falling edges or at the start of a bit. Setup to the sclk rising edge is DIV cycles; hold is DIV cycles.
- The DIV counter wraps from DIV-1 to 0. The bit counter terminates at WIDTH-1 with no wrap.
- DIV=1 is legal: sclk toggles every clk cycle.
- Reset mid-transfer: all outputs return to reset values asynchronously, and the shadow data is discarded. The next transfer includes CLEAR again.

## Test plan
1. Reset then first transfer. Set WIDTH=16, CHANNELS=2, DIV=2, pdata=32'hA5C3_0F01, pulse load for 1 cycle. Required: clr=0 for 2 cycles after busy rises; 16 sclk rising edges; sdo[0] reads 0x0F01 and sdo[1] reads 0xA5C3 MSB first; pen high for 2 cycles; done at k+1+68.
2. Second transfer, LSB first (MSB_FIRST=0, pdata lane0=16'h0001). Required: no CLEAR phase; sdo[0]=1 only at the first sclk edge; done at k+1+66.
3. Busy collision. Pulse load again mid-SHIFT with different pdata. Required: the shifted bits are unchanged, no second transfer starts, and exactly one done pulse occurs.
4. Auto mode. Hold auto=1 for 3 transfers with DIV=1. Required: done pulses 1+(2*16+1) cycles apart with exactly 1 IDLE cycle between transfers, and busy low only in those cycles.
5. Reset mid-SHIFT. Assert rst asynchronously at bit 7. Required: sclk, sdo, pen and busy go to 0 and clr goes to 0 without waiting for a clk edge. The next load performs CLEAR again.
6. Parameter sweep. Run WIDTH=8, CHANNELS=4, DIV=3 with distinct bytes per lane. Required: each lane reproduces its byte, 8 sclk edges per transfer, and T=51 (54 with CLEAR).
